// File: rtl/adc_frame_packetizer.sv
// ADC frame packetizer: wraps PAYLOAD_LEN FIFO bytes in a
// SYNC/SEQ/LEN/payload/CHK/EOD frame for the UART transmitter.
module adc_frame_packetizer #(
  parameter int          PAYLOAD_LEN    = 1024,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter logic [7:0]  EOD_BYTE       = 8'h0A,
  parameter int          TIMEOUT_CYCLES = 1000000
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Start,
  input  logic [7:0] FifoData,
  input  logic       FifoEmpty,
  output logic       FifoRead,
  input  logic       TxBusy,
  output logic [7:0] TxData,
  output logic       TxWrite,
  output logic       Busy,
  output logic [7:0] SeqNum,
  output logic       Underrun
);

  localparam int          TW      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [15:0] LEN     = 16'(PAYLOAD_LEN);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [3:0] {
    IDLE, SYNC, SEQ, LENH, LENL, FETCH,
    LATCH, DATA, CHK, EOD, WAITTX
  } state_t;

  state_t          state;
  state_t          ret_state;
  state_t          tx_next;
  logic [1:0]      wait_cnt;
  logic [7:0]      chk_sum;
  logic [15:0]     byte_cnt;
  logic [TW-1:0]   to_cnt;
  logic [7:0]      data_q;
  logic            lat_ph;
  logic            armed;
  logic            emit;
  logic [7:0]      tx_byte;
  logic            last_byte;

  assign last_byte = (byte_cnt + 16'd1) == LEN;

  // byte and follow-on state for whichever emitting state is active
  always_comb begin
    emit    = 1'b0;
    tx_byte = 8'h00;
    tx_next = IDLE;
    case (state)
      SYNC: begin
        emit    = 1'b1;
        tx_byte = SYNC_BYTE;
        tx_next = SEQ;
      end
      SEQ: begin
        emit    = 1'b1;
        tx_byte = SeqNum;
        tx_next = LENH;
      end
      LENH: begin
        emit    = 1'b1;
        tx_byte = LEN[15:8];
        tx_next = LENL;
      end
      LENL: begin
        emit    = 1'b1;
        tx_byte = LEN[7:0];
        tx_next = FETCH;
      end
      DATA: begin
        emit    = 1'b1;
        tx_byte = data_q;
        tx_next = last_byte ? CHK : FETCH;
      end
      CHK: begin
        emit    = 1'b1;
        tx_byte = Underrun ? ~chk_sum : chk_sum;
        tx_next = EOD;
      end
      EOD: begin
        emit    = 1'b1;
        tx_byte = EOD_BYTE;
        tx_next = IDLE;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state     <= IDLE;
      ret_state <= IDLE;
      wait_cnt  <= 2'd0;
      chk_sum   <= 8'h00;
      byte_cnt  <= 16'd0;
      to_cnt    <= '0;
      data_q    <= 8'h00;
      lat_ph    <= 1'b0;
      armed     <= 1'b0;
      FifoRead  <= 1'b0;
      TxData    <= 8'h00;
      TxWrite   <= 1'b0;
      Busy      <= 1'b0;
      SeqNum    <= 8'h00;
      Underrun  <= 1'b0;
    end else begin
      // Start on the first edge after reset release is not taken
      armed    <= 1'b1;
      FifoRead <= 1'b0;
      TxWrite  <= 1'b0;
      if (emit && !TxBusy) begin
        TxData    <= tx_byte;
        TxWrite   <= 1'b1;
        ret_state <= tx_next;
        wait_cnt  <= 2'd0;
        state     <= WAITTX;
        if (state == DATA) begin
          chk_sum  <= chk_sum + data_q;
          byte_cnt <= byte_cnt + 16'd1;
        end
      end else begin
        case (state)
          IDLE: begin
            if (Start && armed) begin
              state    <= SYNC;
              Busy     <= 1'b1;
              Underrun <= 1'b0;
              chk_sum  <= 8'h00;
              byte_cnt <= 16'd0;
              to_cnt   <= '0;
            end
          end
          FETCH: begin
            if (!FifoEmpty) begin
              FifoRead <= 1'b1;
              to_cnt   <= '0;
              lat_ph   <= 1'b0;
              state    <= LATCH;
            end else if (to_cnt == TO_LAST) begin
              Underrun <= 1'b1;
              to_cnt   <= '0;
              state    <= CHK;
            end else begin
              to_cnt <= to_cnt + 1'b1;
            end
          end
          // FifoRead is registered, so data lands one cycle later
          LATCH: begin
            if (!lat_ph) begin
              lat_ph <= 1'b1;
            end else begin
              lat_ph <= 1'b0;
              data_q <= FifoData;
              state  <= DATA;
            end
          end
          // hold off until the UART has had time to raise TxBusy
          WAITTX: begin
            if (wait_cnt != 2'd2) begin
              wait_cnt <= wait_cnt + 2'd1;
            end else if (!TxBusy) begin
              state <= ret_state;
              if (ret_state == IDLE) begin
                Busy   <= 1'b0;
                SeqNum <= SeqNum + 8'd1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_adc_frame_packetizer.sv
// Directed bench for adc_frame_packetizer with FIFO and
// UART busy models; PAYLOAD_LEN=4, TIMEOUT_CYCLES=50.
module tb_adc_frame_packetizer;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic       Start = 1'b0;
  logic [7:0] FifoData;
  logic       FifoEmpty;
  logic       FifoRead;
  logic       TxBusy;
  logic [7:0] TxData;
  logic       TxWrite;
  logic       Busy;
  logic [7:0] SeqNum;
  logic       Underrun;

  int vectors = 0;
  int miscompares = 0;

  adc_frame_packetizer #(
    .PAYLOAD_LEN(4),
    .SYNC_BYTE(8'hA5),
    .EOD_BYTE(8'h0A),
    .TIMEOUT_CYCLES(50)
  ) dut (
    .Clock(Clock),
    .Reset(Reset),
    .Start(Start),
    .FifoData(FifoData),
    .FifoEmpty(FifoEmpty),
    .FifoRead(FifoRead),
    .TxBusy(TxBusy),
    .TxData(TxData),
    .TxWrite(TxWrite),
    .Busy(Busy),
    .SeqNum(SeqNum),
    .Underrun(Underrun)
  );

  always #5 Clock = ~Clock;

  // FIFO model
  logic [7:0] mem [0:255];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int rd_count = 0;
  bit fifo_clr = 0;
  bit toggle_en = 0;
  bit tog = 0;

  assign FifoEmpty = (rd_ptr == wr_ptr) || (toggle_en && tog);

  always @(posedge Clock) begin
    tog <= ~tog;
    if (fifo_clr) begin
      rd_ptr <= wr_ptr;
    end else if (FifoRead) begin
      FifoData <= mem[rd_ptr[7:0]];
      rd_ptr   <= rd_ptr + 1;
      rd_count <= rd_count + 1;
    end
  end

  // UART model and TX log
  logic [7:0] txlog [0:4095];
  int tx_n = 0;
  int viol = 0;
  int busy_cnt = 0;
  int tx_len = 10;
  bit tx_hold = 0;
  bit prev_wr = 0;

  assign TxBusy = (busy_cnt != 0) || tx_hold;

  always @(posedge Clock) begin
    if (TxWrite) begin
      txlog[tx_n[11:0]] <= TxData;
      tx_n     <= tx_n + 1;
      busy_cnt <= tx_len;
      if (prev_wr || TxBusy) viol <= viol + 1;
    end else if (busy_cnt > 0) begin
      busy_cnt <= busy_cnt - 1;
    end
    prev_wr <= TxWrite;
  end

  initial begin
    #5ms;
    $display("FAIL global_timeout: simulation did not end, required finish");
    $fatal(1);
  end

  task automatic push(input logic [7:0] b);
    mem[wr_ptr[7:0]] = b;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic pulse_start();
    @(negedge Clock);
    Start = 1'b1;
    @(negedge Clock);
    Start = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (Busy && n < 5000) begin
      @(negedge Clock);
      n++;
    end
    vectors++;
    if (Busy !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_idle: Busy=%b after %0d cycles, required 0", nm, Busy, n);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge Clock);
    vectors++;
    if ({FifoRead, TxWrite, Busy, Underrun} !== 4'b0) begin
      miscompares++;
      $display("FAIL reset_flags: got %b, required 0000",
               {FifoRead, TxWrite, Busy, Underrun});
    end
    vectors++;
    if (TxData !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_txdata: got %02h, required 00", TxData);
    end
    vectors++;
    if (SeqNum !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_seq: got %02h, required 00", SeqNum);
    end
    Reset = 1'b0;
  endtask

  task automatic test_basic();
    logic [7:0] exp [10];
    int base;
    int rbase;
    exp = '{8'hA5, 8'h00, 8'h00, 8'h04, 8'h01,
            8'h02, 8'h03, 8'h04, 8'h0A, 8'h0A};
    push(8'h01); push(8'h02); push(8'h03); push(8'h04);
    base = tx_n;
    rbase = rd_count;
    pulse_start();
    vectors++;
    if (Busy !== 1'b1) begin
      miscompares++;
      $display("FAIL basic_busy: got %b, required 1", Busy);
    end
    wait_idle("basic");
    vectors++;
    if (tx_n - base != 10) begin
      miscompares++;
      $display("FAIL basic_len: got %0d bytes, required 10", tx_n - base);
    end
    for (int i = 0; i < 10; i++) begin
      vectors++;
      if (txlog[12'(base + i)] !== exp[i]) begin
        miscompares++;
        $display("FAIL basic_byte%0d: got %02h, required %02h",
                 i, txlog[12'(base + i)], exp[i]);
      end
    end
    vectors++;
    if (rd_count - rbase != 4) begin
      miscompares++;
      $display("FAIL basic_reads: got %0d, required 4", rd_count - rbase);
    end
    vectors++;
    if (SeqNum !== 8'h01) begin
      miscompares++;
      $display("FAIL basic_seq: got %02h, required 01", SeqNum);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] e1 [10];
    logic [7:0] e2 [10];
    int base;
    int rbase;
    e1 = '{8'hA5, 8'h01, 8'h00, 8'h04, 8'h10,
           8'h20, 8'h30, 8'h40, 8'hA0, 8'h0A};
    e2 = '{8'hA5, 8'h02, 8'h00, 8'h04, 8'h05,
           8'h06, 8'h07, 8'h08, 8'h1A, 8'h0A};
    push(8'h10); push(8'h20); push(8'h30); push(8'h40);
    push(8'h05); push(8'h06); push(8'h07); push(8'h08);
    base = tx_n;
    rbase = rd_count;
    pulse_start();
    repeat (20) @(negedge Clock);
    pulse_start();
    wait_idle("b2b1");
    vectors++;
    if (tx_n - base != 10) begin
      miscompares++;
      $display("FAIL b2b1_len: got %0d bytes, required 10", tx_n - base);
    end
    for (int i = 0; i < 10; i++) begin
      vectors++;
      if (txlog[12'(base + i)] !== e1[i]) begin
        miscompares++;
        $display("FAIL b2b1_byte%0d: got %02h, required %02h",
                 i, txlog[12'(base + i)], e1[i]);
      end
    end
    vectors++;
    if (rd_count - rbase != 4) begin
      miscompares++;
      $display("FAIL b2b1_reads: got %0d, required 4", rd_count - rbase);
    end
    repeat (20) @(negedge Clock);
    vectors++;
    if (Busy !== 1'b0 || tx_n - base != 10) begin
      miscompares++;
      $display("FAIL b2b_ignored: Busy=%b bytes=%0d, required 0 and 10",
               Busy, tx_n - base);
    end
    base = tx_n;
    pulse_start();
    wait_idle("b2b2");
    for (int i = 0; i < 10; i++) begin
      vectors++;
      if (txlog[12'(base + i)] !== e2[i]) begin
        miscompares++;
        $display("FAIL b2b2_byte%0d: got %02h, required %02h",
                 i, txlog[12'(base + i)], e2[i]);
      end
    end
    vectors++;
    if (SeqNum !== 8'h03) begin
      miscompares++;
      $display("FAIL b2b_seq: got %02h, required 03", SeqNum);
    end
  endtask

  task automatic test_timeout();
    logic [7:0] exp [8];
    int base;
    exp = '{8'hA5, 8'h03, 8'h00, 8'h04,
            8'h01, 8'h02, 8'hFC, 8'h0A};
    push(8'h01); push(8'h02);
    base = tx_n;
    pulse_start();
    wait_idle("timeout");
    vectors++;
    if (tx_n - base != 8) begin
      miscompares++;
      $display("FAIL timeout_len: got %0d bytes, required 8", tx_n - base);
    end
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if (txlog[12'(base + i)] !== exp[i]) begin
        miscompares++;
        $display("FAIL timeout_byte%0d: got %02h, required %02h",
                 i, txlog[12'(base + i)], exp[i]);
      end
    end
    vectors++;
    if (Underrun !== 1'b1) begin
      miscompares++;
      $display("FAIL timeout_underrun: got %b, required 1", Underrun);
    end
    vectors++;
    if (SeqNum !== 8'h04) begin
      miscompares++;
      $display("FAIL timeout_seq: got %02h, required 04", SeqNum);
    end
  endtask

  task automatic test_checksum_wrap();
    logic [7:0] exp [10];
    int base;
    exp = '{8'hA5, 8'h04, 8'h00, 8'h04, 8'hFF,
            8'hFF, 8'hFF, 8'hFF, 8'hFC, 8'h0A};
    repeat (4) push(8'hFF);
    base = tx_n;
    pulse_start();
    vectors++;
    if (Underrun !== 1'b0) begin
      miscompares++;
      $display("FAIL wrap_underrun_clr: got %b, required 0", Underrun);
    end
    wait_idle("wrap");
    for (int i = 0; i < 10; i++) begin
      vectors++;
      if (txlog[12'(base + i)] !== exp[i]) begin
        miscompares++;
        $display("FAIL wrap_byte%0d: got %02h, required %02h",
                 i, txlog[12'(base + i)], exp[i]);
      end
    end
  endtask

  task automatic test_txbusy_hold();
    logic [7:0] exp [10];
    int base;
    int n = 0;
    exp = '{8'hA5, 8'h05, 8'h00, 8'h04, 8'h11,
            8'h22, 8'h33, 8'h44, 8'hAA, 8'h0A};
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    base = tx_n;
    pulse_start();
    while (tx_n == base && n < 100) begin
      @(negedge Clock);
      n++;
    end
    vectors++;
    if (tx_n != base + 1) begin
      miscompares++;
      $display("FAIL hold_sync: got %0d bytes, required 1", tx_n - base);
    end
    tx_hold = 1'b1;
    repeat (100) @(negedge Clock);
    vectors++;
    if (tx_n != base + 1) begin
      miscompares++;
      $display("FAIL hold_stall: got %0d bytes, required 1", tx_n - base);
    end
    tx_hold = 1'b0;
    wait_idle("hold");
    for (int i = 0; i < 10; i++) begin
      vectors++;
      if (txlog[12'(base + i)] !== exp[i]) begin
        miscompares++;
        $display("FAIL hold_byte%0d: got %02h, required %02h",
                 i, txlog[12'(base + i)], exp[i]);
      end
    end
  endtask

  task automatic test_empty_toggle();
    logic [7:0] exp [10];
    int base;
    exp = '{8'hA5, 8'h06, 8'h00, 8'h04, 8'h80,
            8'h01, 8'h7F, 8'h02, 8'h02, 8'h0A};
    toggle_en = 1'b1;
    push(8'h80); push(8'h01); push(8'h7F); push(8'h02);
    base = tx_n;
    pulse_start();
    wait_idle("toggle");
    toggle_en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      vectors++;
      if (txlog[12'(base + i)] !== exp[i]) begin
        miscompares++;
        $display("FAIL toggle_byte%0d: got %02h, required %02h",
                 i, txlog[12'(base + i)], exp[i]);
      end
    end
    vectors++;
    if (Underrun !== 1'b0 || SeqNum !== 8'h07) begin
      miscompares++;
      $display("FAIL toggle_status: Underrun=%b Seq=%02h, required 0 and 07",
               Underrun, SeqNum);
    end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] exp [10];
    int base;
    int rbase;
    int n = 0;
    exp = '{8'hA5, 8'h00, 8'h00, 8'h04, 8'h01,
            8'h01, 8'h01, 8'h01, 8'h04, 8'h0A};
    push(8'h01); push(8'h02); push(8'h03); push(8'h04);
    rbase = rd_count;
    pulse_start();
    while (rd_count < rbase + 2 && n < 500) begin
      @(negedge Clock);
      n++;
    end
    vectors++;
    if (rd_count != rbase + 2) begin
      miscompares++;
      $display("FAIL rst_reach: got %0d reads, required 2", rd_count - rbase);
    end
    Reset = 1'b1;
    #1;
    vectors++;
    if ({FifoRead, TxWrite, Busy} !== 3'b000 || SeqNum !== 8'h00) begin
      miscompares++;
      $display("FAIL rst_mid: rd/wr/busy=%b seq=%02h, required 000 and 00",
               {FifoRead, TxWrite, Busy}, SeqNum);
    end
    fifo_clr = 1'b1;
    @(negedge Clock);
    fifo_clr = 1'b0;
    @(negedge Clock);
    Reset = 1'b0;
    Start = 1'b1;
    @(negedge Clock);
    Start = 1'b0;
    vectors++;
    if (Busy !== 1'b0 || FifoRead !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_start_ignored: Busy=%b FifoRead=%b, required 0 0",
               Busy, FifoRead);
    end
    push(8'h01); push(8'h01); push(8'h01); push(8'h01);
    base = tx_n;
    pulse_start();
    wait_idle("rst_fresh");
    for (int i = 0; i < 10; i++) begin
      vectors++;
      if (txlog[12'(base + i)] !== exp[i]) begin
        miscompares++;
        $display("FAIL rst_byte%0d: got %02h, required %02h",
                 i, txlog[12'(base + i)], exp[i]);
      end
    end
    vectors++;
    if (SeqNum !== 8'h01) begin
      miscompares++;
      $display("FAIL rst_seq: got %02h, required 01", SeqNum);
    end
  endtask

  task automatic test_seq_wrap();
    int base = 0;
    tx_len = 1;
    for (int f = 0; f < 255; f++) begin
      repeat (4) push(8'h00);
      base = tx_n;
      pulse_start();
      wait_idle("seqwrap");
    end
    vectors++;
    if (txlog[12'(base + 1)] !== 8'hFF) begin
      miscompares++;
      $display("FAIL seqwrap_last: got %02h, required FF", txlog[12'(base + 1)]);
    end
    vectors++;
    if (SeqNum !== 8'h00) begin
      miscompares++;
      $display("FAIL seqwrap_num: got %02h, required 00", SeqNum);
    end
    tx_len = 10;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_timeout();
    test_checksum_wrap();
    test_txbusy_hold();
    test_empty_toggle();
    test_reset_midframe();
    test_seq_wrap();
    vectors++;
    if (viol != 0) begin
      miscompares++;
      $display("FAIL tx_protocol: %0d bad TxWrites, required 0", viol);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
